// File: rtl/calc_sequencer.sv
// Sequenced calculator: add/subtract/shift-add multiply on two 8-bit operands,
// then double-dabble conversion of the 16-bit magnitude into five BCD digits.
module calc_sequencer (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        clear,
    input  logic [1:0]  calculation,
    input  logic [7:0]  numA,
    input  logic [7:0]  numB,
    output logic        busy,
    output logic        done,
    output logic        neg,
    output logic [19:0] result_bcd
);

    // Operation encoding mirrors the CALC_* definitions of global.v
    localparam logic [1:0] CALC_RST   = 2'b00;
    localparam logic [1:0] CALC_ADD   = 2'b01;
    localparam logic [1:0] CALC_SUB   = 2'b10;
    localparam logic [1:0] CALC_MULTI = 2'b11;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LOAD = 3'd1,
        MUL  = 3'd2,
        CONV = 3'd3,
        DONE = 3'd4
    } state_t;

    state_t      state;
    state_t      next_state;

    logic [7:0]  op_a;
    logic [7:0]  op_b;
    logic [1:0]  op_code;
    logic [15:0] mag;
    logic [15:0] a_shift;
    logic [19:0] bcd_work;
    logic        neg_work;
    logic [3:0]  cnt;

    logic [8:0]  sum_ab;
    logic [15:0] mul_addend;
    logic [35:0] conv_next;

    function automatic logic [19:0] dd_adjust(input logic [19:0] bcd);
        logic [19:0] r;
        r = bcd;
        for (int i = 0; i < 5; i++) begin
            if (r[i*4 +: 4] >= 4'd5)
                r[i*4 +: 4] = r[i*4 +: 4] + 4'd3;
        end
        return r;
    endfunction

    assign sum_ab     = {1'b0, op_a} + {1'b0, op_b};
    assign mul_addend = op_b[0] ? a_shift : 16'd0;
    assign conv_next  = {dd_adjust(bcd_work), mag} << 1;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            state <= IDLE;
        else
            state <= next_state;
    end

    always_comb begin
        next_state = state;
        busy       = 1'b1;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (start && (calculation != CALC_RST))
                    next_state = LOAD;
            end
            LOAD:    next_state = (op_code == CALC_MULTI) ? MUL : CONV;
            MUL:     next_state = (cnt == 4'd7) ? CONV : MUL;
            CONV:    next_state = (cnt == 4'd15) ? DONE : CONV;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
        if (clear)
            next_state = IDLE;
    end

    // Multiplier bits are consumed LSB first by shifting op_b right in place
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            op_a       <= 8'd0;
            op_b       <= 8'd0;
            op_code    <= CALC_RST;
            mag        <= 16'd0;
            a_shift    <= 16'd0;
            bcd_work   <= 20'd0;
            neg_work   <= 1'b0;
            cnt        <= 4'd0;
            result_bcd <= 20'd0;
            neg        <= 1'b0;
            done       <= 1'b0;
        end else if (clear) begin
            op_a       <= 8'd0;
            op_b       <= 8'd0;
            op_code    <= CALC_RST;
            mag        <= 16'd0;
            a_shift    <= 16'd0;
            bcd_work   <= 20'd0;
            neg_work   <= 1'b0;
            cnt        <= 4'd0;
            result_bcd <= 20'd0;
            neg        <= 1'b0;
            done       <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (calculation == CALC_RST) begin
                            result_bcd <= 20'd0;
                            neg        <= 1'b0;
                        end else begin
                            op_a    <= numA;
                            op_b    <= numB;
                            op_code <= calculation;
                        end
                    end
                end
                LOAD: begin
                    cnt      <= 4'd0;
                    bcd_work <= 20'd0;
                    neg_work <= 1'b0;
                    case (op_code)
                        CALC_ADD: mag <= {7'd0, sum_ab};
                        CALC_SUB: begin
                            if (op_a >= op_b) begin
                                mag <= {8'd0, op_a - op_b};
                            end else begin
                                mag      <= {8'd0, op_b - op_a};
                                neg_work <= 1'b1;
                            end
                        end
                        CALC_MULTI: begin
                            mag     <= 16'd0;
                            a_shift <= {8'd0, op_a};
                        end
                        default: mag <= 16'd0;
                    endcase
                end
                MUL: begin
                    mag     <= mag + mul_addend;
                    a_shift <= a_shift << 1;
                    op_b    <= op_b >> 1;
                    cnt     <= (cnt == 4'd7) ? 4'd0 : cnt + 4'd1;
                end
                CONV: begin
                    bcd_work <= conv_next[35:16];
                    mag      <= conv_next[15:0];
                    cnt      <= (cnt == 4'd15) ? 4'd0 : cnt + 4'd1;
                end
                DONE: begin
                    result_bcd <= bcd_work;
                    neg        <= neg_work;
                    done       <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule
